reorder_buffer: RTL and testbench

- Circular reorder buffer for the out-of-order core.
- Allocates one entry per dispatched instruction in program order and returns its index.
- Accepts result write-backs from three functional units: ALU, LSU and MUL.
- Retires completed entries in order, one per cycle, presenting the committed instruction, PC, destination register and value to the architectural register file.

---
 rtl/reorder_buffer.sv | 138 +++++++++++++
 tb/tb_reorder_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, ALU/LSU/MUL write-back, in-order single commit.
// Optional macro ROB_FLUSH_EN adds a flush_i port that clears the whole buffer.
module reorder_buffer #(
  parameter  int DEPTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
`ifdef ROB_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             allocate_req_i,
  input  logic             update_req_alu_i,
  input  logic             update_req_lsu_i,
  input  logic             update_req_mul_i,
  input  logic [4:0]       prd_addr_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      rob_idx_alu_i,
  input  logic [31:0]      reg_value_alu_i,
  input  logic [31:0]      rob_idx_lsu_i,
  input  logic [31:0]      reg_value_lsu_i,
  input  logic [31:0]      rob_idx_mul_i,
  input  logic [31:0]      reg_value_mul_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [IDX_W-1:0] rob_idx_o,
  output logic             commitment_valid_o,
  output logic [31:0]      inst_committed_o,
  output logic [31:0]      pc_committed_o,
  output logic [4:0]       prd_addr_committed_o,
  output logic [31:0]      prd_value_committed_o
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_ready;
  logic [31:0]      r_inst  [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [4:0]       r_prd   [DEPTH];
  logic [31:0]      r_value [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic             w_flush;
  logic             w_full;
  logic             w_alloc;
  logic             w_commit;
  logic [IDX_W-1:0] w_alu_idx;
  logic [IDX_W-1:0] w_lsu_idx;
  logic [IDX_W-1:0] w_mul_idx;
  logic [DEPTH-1:0] w_alloc_mask;
  logic [DEPTH-1:0] w_commit_mask;
  logic [DEPTH-1:0] w_upd_alu;
  logic [DEPTH-1:0] w_upd_lsu;
  logic [DEPTH-1:0] w_upd_mul;
  logic             w_unused;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  assign w_alu_idx = rob_idx_alu_i[IDX_W-1:0];
  assign w_lsu_idx = rob_idx_lsu_i[IDX_W-1:0];
  assign w_mul_idx = rob_idx_mul_i[IDX_W-1:0];
  assign w_unused  = ^{rob_idx_alu_i[31:IDX_W], rob_idx_lsu_i[31:IDX_W], rob_idx_mul_i[31:IDX_W]};

  assign w_full   = (r_count == (IDX_W+1)'(DEPTH));
  assign w_alloc  = allocate_req_i & ~w_full & ~w_flush;
  assign w_commit = r_valid[r_head] & r_ready[r_head] & ~w_flush;

  // Per-entry decode; write-backs only land on entries that are currently valid.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign w_alloc_mask[gi]  = w_alloc  && (r_tail == IDX_W'(gi));
      assign w_commit_mask[gi] = w_commit && (r_head == IDX_W'(gi));
      assign w_upd_alu[gi] = update_req_alu_i && (w_alu_idx == IDX_W'(gi)) && r_valid[gi];
      assign w_upd_lsu[gi] = update_req_lsu_i && (w_lsu_idx == IDX_W'(gi)) && r_valid[gi];
      assign w_upd_mul[gi] = update_req_mul_i && (w_mul_idx == IDX_W'(gi)) && r_valid[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= (r_valid | w_alloc_mask) & ~w_commit_mask;
      r_ready <= (r_ready | w_upd_alu | w_upd_lsu | w_upd_mul) & ~w_commit_mask & ~w_alloc_mask;
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid/ready.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc_mask[i]) begin
        r_inst[i]  <= inst_i;
        r_pc[i]    <= pc_i;
        r_prd[i]   <= prd_addr_i;
        r_value[i] <= '0;
      end else if (w_upd_alu[i]) begin
        r_value[i] <= reg_value_alu_i;
      end else if (w_upd_lsu[i]) begin
        r_value[i] <= reg_value_lsu_i;
      end else if (w_upd_mul[i]) begin
        r_value[i] <= reg_value_mul_i;
      end
    end
  end

  assign empty_o               = (r_count == '0);
  assign full_o                = w_full;
  assign rob_idx_o             = r_tail;
  assign commitment_valid_o    = w_commit;
  assign inst_committed_o      = w_commit ? r_inst[r_head]  : '0;
  assign pc_committed_o        = w_commit ? r_pc[r_head]    : '0;
  assign prd_addr_committed_o  = w_commit ? r_prd[r_head]   : '0;
  assign prd_value_committed_o = w_commit ? r_value[r_head] : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations are queued in program order,
// a negedge monitor pops and checks every commit against the bench model.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        allocate_req_i;
  logic        update_req_alu_i, update_req_lsu_i, update_req_mul_i;
  logic [4:0]  prd_addr_i;
  logic [31:0] pc_i, inst_i;
  logic [31:0] rob_idx_alu_i, reg_value_alu_i;
  logic [31:0] rob_idx_lsu_i, reg_value_lsu_i;
  logic [31:0] rob_idx_mul_i, reg_value_mul_i;
  logic        empty_o, full_o, commitment_valid_o;
  logic [4:0]  rob_idx_o, prd_addr_committed_o;
  logic [31:0] inst_committed_o, pc_committed_o, prd_value_committed_o;

  reorder_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .allocate_req_i(allocate_req_i),
    .update_req_alu_i(update_req_alu_i), .update_req_lsu_i(update_req_lsu_i),
    .update_req_mul_i(update_req_mul_i),
    .prd_addr_i(prd_addr_i), .pc_i(pc_i), .inst_i(inst_i),
    .rob_idx_alu_i(rob_idx_alu_i), .reg_value_alu_i(reg_value_alu_i),
    .rob_idx_lsu_i(rob_idx_lsu_i), .reg_value_lsu_i(reg_value_lsu_i),
    .rob_idx_mul_i(rob_idx_mul_i), .reg_value_mul_i(reg_value_mul_i),
    .empty_o(empty_o), .full_o(full_o), .rob_idx_o(rob_idx_o),
    .commitment_valid_o(commitment_valid_o),
    .inst_committed_o(inst_committed_o), .pc_committed_o(pc_committed_o),
    .prd_addr_committed_o(prd_addr_committed_o),
    .prd_value_committed_o(prd_value_committed_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bench model of the buffer contents
  logic [4:0]  q[$];
  logic [4:0]  m_prd  [32];
  logic [31:0] m_pc   [32];
  logic [31:0] m_inst [32];
  logic [31:0] m_val  [32];
  bit          m_valid[32];
  bit          m_ready[32];
  logic [4:0]  m_tail = 5'd0;

  // Staged stimulus, folded into the model at the edge that applies it
  bit          s_alloc, s_alu, s_lsu, s_mul;
  logic [4:0]  s_prd, s_alu_idx, s_lsu_idx, s_mul_idx;
  logic [31:0] s_pc, s_inst, s_alu_val, s_lsu_val, s_mul_val;

  task automatic do_alloc(input logic [4:0] prd, input logic [31:0] pc, input logic [31:0] inst);
    allocate_req_i = 1'b1;
    prd_addr_i = prd; pc_i = pc; inst_i = inst;
    if (q.size() < 32) begin
      s_alloc = 1'b1; s_prd = prd; s_pc = pc; s_inst = inst;
    end
  endtask

  task automatic upd_alu(input logic [4:0] idx, input logic [31:0] val);
    update_req_alu_i = 1'b1;
    rob_idx_alu_i = {27'($urandom), idx};
    reg_value_alu_i = val;
    s_alu = 1'b1; s_alu_idx = idx; s_alu_val = val;
  endtask

  task automatic upd_lsu(input logic [4:0] idx, input logic [31:0] val);
    update_req_lsu_i = 1'b1;
    rob_idx_lsu_i = {27'($urandom), idx};
    reg_value_lsu_i = val;
    s_lsu = 1'b1; s_lsu_idx = idx; s_lsu_val = val;
  endtask

  task automatic upd_mul(input logic [4:0] idx, input logic [31:0] val);
    update_req_mul_i = 1'b1;
    rob_idx_mul_i = {27'($urandom), idx};
    reg_value_mul_i = val;
    s_mul = 1'b1; s_mul_idx = idx; s_mul_val = val;
  endtask

  task automatic tick();
    @(posedge clk_i);
    // lowest priority first so ALU overwrites
    if (s_mul && m_valid[s_mul_idx]) begin m_val[s_mul_idx] = s_mul_val; m_ready[s_mul_idx] = 1'b1; end
    if (s_lsu && m_valid[s_lsu_idx]) begin m_val[s_lsu_idx] = s_lsu_val; m_ready[s_lsu_idx] = 1'b1; end
    if (s_alu && m_valid[s_alu_idx]) begin m_val[s_alu_idx] = s_alu_val; m_ready[s_alu_idx] = 1'b1; end
    if (s_alloc) begin
      m_valid[m_tail] = 1'b1; m_ready[m_tail] = 1'b0; m_val[m_tail] = 32'd0;
      m_prd[m_tail] = s_prd; m_pc[m_tail] = s_pc; m_inst[m_tail] = s_inst;
      q.push_back(m_tail);
      m_tail = m_tail + 5'd1;
    end
    s_alloc = 1'b0; s_alu = 1'b0; s_lsu = 1'b0; s_mul = 1'b0;
    #1;
    allocate_req_i = 1'b0;
    update_req_alu_i = 1'b0; update_req_lsu_i = 1'b0; update_req_mul_i = 1'b0;
  endtask

  // Commit monitor
  bit         mon_exp_cv;
  logic [4:0] mon_idx;
  always @(negedge clk_i) begin
    if (!reset_i) begin
      mon_exp_cv = (q.size() > 0) && m_ready[q[0]];
      chk("commit_valid", {31'd0, commitment_valid_o}, {31'd0, mon_exp_cv});
      if (mon_exp_cv && commitment_valid_o) begin
        mon_idx = q.pop_front();
        chk("commit_prd",   {27'd0, prd_addr_committed_o}, {27'd0, m_prd[mon_idx]});
        chk("commit_pc",    pc_committed_o,        m_pc[mon_idx]);
        chk("commit_inst",  inst_committed_o,      m_inst[mon_idx]);
        chk("commit_value", prd_value_committed_o, m_val[mon_idx]);
        m_valid[mon_idx] = 1'b0;
        m_ready[mon_idx] = 1'b0;
      end else if (!commitment_valid_o) begin
        chk("commit_data_zero",
            inst_committed_o | pc_committed_o | prd_value_committed_o | {27'd0, prd_addr_committed_o},
            32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [4:0]  a_prd  [5] = '{5'd5, 5'd3, 5'd6, 5'd4, 5'd1};
  logic [31:0] a_pc   [5] = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10};
  logic [31:0] a_inst [5] = '{32'h5a000093, 32'h22600113, 32'h0220e2b3, 32'h00010093, 32'h00028113};
  logic [4:0]  snap[$];
  int          guard;

  initial begin
    reset_i = 1'b1;
    allocate_req_i = 1'b0;
    update_req_alu_i = 1'b0; update_req_lsu_i = 1'b0; update_req_mul_i = 1'b0;
    prd_addr_i = '0; pc_i = '0; inst_i = '0;
    rob_idx_alu_i = '0; rob_idx_lsu_i = '0; rob_idx_mul_i = '0;
    reg_value_alu_i = '0; reg_value_lsu_i = '0; reg_value_mul_i = '0;
    s_alloc = 0; s_alu = 0; s_lsu = 0; s_mul = 0;
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_ready[i] = 0; end
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    chk("rst_empty",   {31'd0, empty_o}, 32'd1);
    chk("rst_full",    {31'd0, full_o}, 32'd0);
    chk("rst_rob_idx", {27'd0, rob_idx_o}, 32'd0);
    chk("rst_cv",      {31'd0, commitment_valid_o}, 32'd0);

    // Five back-to-back allocations; entry 0 completes with the third
    for (int i = 0; i < 5; i++) begin
      chk("alloc_rob_idx_pre", {27'd0, rob_idx_o}, i);
      do_alloc(a_prd[i], a_pc[i], a_inst[i]);
      if (i == 2) upd_alu(5'd0, 32'd0);
      tick();
      chk("alloc_rob_idx_post", {27'd0, rob_idx_o}, i + 1);
      chk("alloc_empty", {31'd0, empty_o}, 32'd0);
      if (i == 2) begin
        chk("idx0_cv",   {31'd0, commitment_valid_o}, 32'd1);
        chk("idx0_prd",  {27'd0, prd_addr_committed_o}, 32'd5);
        chk("idx0_inst", inst_committed_o, 32'h5a000093);
      end
    end

    // Out-of-order completion, in-order retirement
    upd_alu(5'd2, 32'd0);
    tick();
    chk("idx1_blocks", {31'd0, commitment_valid_o}, 32'd0);
    upd_alu(5'd1, 32'd5);
    upd_lsu(5'd3, 32'd4);
    tick();
    chk("ret_idx1_value", prd_value_committed_o, 32'd5);
    tick();
    chk("ret_idx2_pc", pc_committed_o, 32'h8);
    tick();
    chk("ret_idx3_pc", pc_committed_o, 32'hc);
    tick();
    chk("idx4_pending_cv", {31'd0, commitment_valid_o}, 32'd0);
    chk("idx4_pending_empty", {31'd0, empty_o}, 32'd0);

    // Fill through the wrap point
    guard = 0;
    while (q.size() < 32 && guard < 40) begin
      do_alloc(5'($urandom), $urandom, $urandom);
      tick();
      guard++;
    end
    chk("full_set", {31'd0, full_o}, 32'd1);
    chk("full_rob_idx", {27'd0, rob_idx_o}, 32'd4);
    do_alloc(5'd7, 32'hdead, 32'hbeef);
    tick();
    chk("full_drop_idx", {27'd0, rob_idx_o}, 32'd4);
    chk("full_hold", {31'd0, full_o}, 32'd1);

    // Allocate while full and committing is still dropped
    upd_alu(5'd4, 32'h44);
    tick();
    do_alloc(5'd8, 32'h100, 32'h200);
    tick();
    chk("full_commit_drop_full", {31'd0, full_o}, 32'd0);
    chk("full_commit_drop_idx", {27'd0, rob_idx_o}, 32'd4);
    do_alloc(5'd9, 32'h104, 32'h204);
    tick();
    chk("resume_idx", {27'd0, rob_idx_o}, 32'd5);
    chk("resume_full", {31'd0, full_o}, 32'd1);

    // Write-back priority on a shared index
    upd_alu(5'd5, 32'haaaa);
    upd_mul(5'd5, 32'hbbbb);
    tick();
    chk("alu_over_mul", prd_value_committed_o, 32'haaaa);
    upd_lsu(5'd6, 32'h1111);
    upd_mul(5'd6, 32'h2222);
    tick();
    chk("lsu_over_mul", prd_value_committed_o, 32'h1111);

    // Drain the rest
    snap = q;
    foreach (snap[k]) begin
      if (!m_ready[snap[k]]) upd_alu(snap[k], $urandom);
      tick();
    end
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_done", q.size(), 32'd0);
    chk("drain_empty", {31'd0, empty_o}, 32'd1);
    chk("drain_full", {31'd0, full_o}, 32'd0);
    chk("drain_rob_idx", {27'd0, rob_idx_o}, {27'd0, m_tail});

    // Write-back to an invalid entry has no effect
    upd_mul(m_tail, 32'h99);
    tick();
    chk("invalid_upd_cv", {31'd0, commitment_valid_o}, 32'd0);
    chk("invalid_upd_empty", {31'd0, empty_o}, 32'd1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
